sakebi_crc32_checker: RTL

//  Receive-side Ethernet FCS checker; counterpart of the transmit CRC32 generator.
//  - Consumes a byte stream of frame data followed by its 4-byte FCS.
//  - Forwards the payload with the FCS stripped.
//  - Reports a pass/fail verdict at end of frame.
//  - Sits between the RX deframer and the packet parser; no backpressure.

---
 rtl/sakebi_crc32_checker.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sakebi_crc32_checker.sv
// Receive-side Ethernet FCS checker: strips the 4-byte FCS, forwards payload, reports a verdict per frame.
// Optional statistics counters (o_good_cnt/o_bad_cnt) are enabled by defining SAKEBI_CRC32_CHK_STATS_EN.
module sakebi_crc32_checker #(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] CRC_POLY    = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3,
    parameter int          LEN_WIDTH   = 16
) (
    input  logic                  i_axis_ACLK,
    input  logic                  i_axis_ARESETn,
    input  logic                  i_axis_TVALID,
    input  logic [DATA_WIDTH-1:0] i_axis_TDATA,
    output logic                  o_axis_TVALID,
    output logic [DATA_WIDTH-1:0] o_axis_TDATA,
    output logic                  o_axis_TLAST,
    output logic                  o_fcs_valid,
    output logic                  o_fcs_ok
`ifdef SAKEBI_CRC32_CHK_STATS_EN
    ,
    output logic [15:0]           o_good_cnt,
    output logic [15:0]           o_bad_cnt
`endif
);

    localparam logic [1:0]           S_IDLE   = 2'b00;
    localparam logic [1:0]           S_RECV   = 2'b01;
    localparam logic [LEN_WIDTH-1:0] LEN_FCS1 = LEN_WIDTH'(5);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = {LEN_WIDTH{1'b1}};

    // Reflected CRC-32 update, one data bit per iteration, LSB first.
    function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                               input logic [DATA_WIDTH-1:0] d);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ d[i]}});
        end
        return c;
    endfunction

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [31:0]                r_crc;
    logic [31:0]                w_crc_nxt;
    logic [LEN_WIDTH-1:0]       r_cnt;
    logic [LEN_WIDTH-1:0]       w_cnt_nxt;
    logic [4:0][DATA_WIDTH-1:0] r_dl;
    logic [4:0][DATA_WIDTH-1:0] w_dl_nxt;
    logic                       w_tvalid_nxt;
    logic [DATA_WIDTH-1:0]      w_tdata_nxt;
    logic                       w_tlast_nxt;
    logic                       w_fcs_valid_nxt;
    logic                       w_fcs_ok_nxt;
    logic                       w_past_fcs;

    // Once five bytes are held, the oldest one in the delay line cannot be FCS.
    assign w_past_fcs = (r_cnt >= LEN_FCS1);

    // State register
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a frame is one contiguous TVALID run
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = i_axis_TVALID ? S_RECV : S_IDLE;
            S_RECV:  w_state_nxt = i_axis_TVALID ? S_RECV : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        w_crc_nxt       = r_crc;
        w_cnt_nxt       = r_cnt;
        w_dl_nxt        = r_dl;
        w_tvalid_nxt    = 1'b0;
        w_tdata_nxt     = o_axis_TDATA;
        w_tlast_nxt     = 1'b0;
        w_fcs_valid_nxt = 1'b0;
        w_fcs_ok_nxt    = o_fcs_ok;
        case (r_state)
            S_IDLE: begin
                if (i_axis_TVALID) begin
                    w_crc_nxt = crc_update(CRC_INIT, i_axis_TDATA);
                    w_cnt_nxt = LEN_WIDTH'(1);
                    w_dl_nxt  = {r_dl[3:0], i_axis_TDATA};
                end else begin
                    w_crc_nxt = CRC_INIT;
                    w_cnt_nxt = '0;
                end
            end
            S_RECV: begin
                if (i_axis_TVALID) begin
                    w_crc_nxt = crc_update(r_crc, i_axis_TDATA);
                    w_cnt_nxt = (r_cnt == LEN_MAX) ? r_cnt : r_cnt + LEN_WIDTH'(1);
                    w_dl_nxt  = {r_dl[3:0], i_axis_TDATA};
                    if (w_past_fcs) begin
                        w_tvalid_nxt = 1'b1;
                        w_tdata_nxt  = r_dl[4];
                    end else begin
                        w_tvalid_nxt = 1'b0;
                    end
                end else begin
                    if (w_past_fcs) begin
                        w_tvalid_nxt = 1'b1;
                        w_tdata_nxt  = r_dl[4];
                        w_tlast_nxt  = 1'b1;
                    end else begin
                        w_tvalid_nxt = 1'b0;
                    end
                    w_fcs_valid_nxt = 1'b1;
                    w_fcs_ok_nxt    = (r_crc == CRC_RESIDUE) && w_past_fcs;
                    w_crc_nxt       = CRC_INIT;
                    w_cnt_nxt       = '0;
                end
            end
            default: begin
                w_crc_nxt = CRC_INIT;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_crc         <= CRC_INIT;
            r_cnt         <= '0;
            r_dl          <= '0;
            o_axis_TVALID <= 1'b0;
            o_axis_TDATA  <= '0;
            o_axis_TLAST  <= 1'b0;
            o_fcs_valid   <= 1'b0;
            o_fcs_ok      <= 1'b0;
        end else begin
            r_crc         <= w_crc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_dl          <= w_dl_nxt;
            o_axis_TVALID <= w_tvalid_nxt;
            o_axis_TDATA  <= w_tdata_nxt;
            o_axis_TLAST  <= w_tlast_nxt;
            o_fcs_valid   <= w_fcs_valid_nxt;
            o_fcs_ok      <= w_fcs_ok_nxt;
        end
    end

`ifdef SAKEBI_CRC32_CHK_STATS_EN
    // Saturating good/bad frame counters, updated the cycle after each verdict
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            o_good_cnt <= 16'd0;
            o_bad_cnt  <= 16'd0;
        end else if (o_fcs_valid) begin
            if (o_fcs_ok) begin
                if (o_good_cnt != 16'hFFFF) begin
                    o_good_cnt <= o_good_cnt + 16'd1;
                end
            end else begin
                if (o_bad_cnt != 16'hFFFF) begin
                    o_bad_cnt <= o_bad_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule
